// File: rtl/mult_share_arbiter_pkg.sv
// Shared defaults, op record and dequantize helper for mult_share_arbiter.
// Build option MULT_SHARE_SAT_EN: clamp dequantized products instead of wrapping.
package mult_share_arbiter_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_QUANT_BITS = 10;
    localparam int unsigned MAX_DW         = 64;
    localparam int unsigned TAG_W          = 3;

    typedef logic signed [2*MAX_DW-1:0] wide_t;

    typedef struct packed {
        logic signed [DEF_DATA_WIDTH-1:0] a;
        logic signed [DEF_DATA_WIDTH-1:0] b;
        logic [TAG_W-1:0]                 tag;
        logic                             v;
    } mult_op_t;

    // Returns the dw-bit result sign-extended to wide_t; callers size-cast it down.
    function automatic wide_t dequantize(wide_t p, int unsigned qbits, int unsigned dw);
        wide_t s;
`ifdef MULT_SHARE_SAT_EN
        wide_t hi;
        wide_t lo;
        s  = p >>> qbits;
        hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (s > hi)
            s = hi;
        else if (s < lo)
            s = lo;
`else
        s = p >>> qbits;
        s = (s <<< (2*MAX_DW - dw)) >>> (2*MAX_DW - dw);
`endif
        return s;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Client-side request/response bundle for the shared multiplier.
interface mult_share_arbiter_if
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [DATA_WIDTH-1:0]              rsp_data;
    logic                               busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin grant: search starts at ptr and wraps at N.
module mult_share_arbiter_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned IW = $clog2(N);

    logic [IW:0] pos;
    logic        found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(N))
                pos = pos - (IW+1)'(N);
            if (!found && req[pos[IW-1:0]]) begin
                found                 = 1'b1;
                grant[pos[IW-1:0]]    = 1'b1;
                grant_idx             = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler for one shared signed multiplier; fixed 2-cycle latency.
// Build option MULT_SHARE_SAT_EN selects saturating dequantization.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned QUANT_BITS = DEF_QUANT_BITS
) (
    input  logic                clock,
    input  logic                reset,
    mult_share_arbiter_if.slave bus
);

    localparam int unsigned TW = $clog2(NUM_REQ);

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] a;
        logic signed [DATA_WIDTH-1:0] b;
        logic [TW-1:0]                tag;
        logic                         v;
    } s1_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] res;
        logic [TW-1:0]         tag;
        logic                  v;
    } s2_t;

    logic [TW-1:0]                  ptr;
    logic [TW-1:0]                  grant_idx;
    logic [NUM_REQ-1:0]             grant;
    logic                           accept;
    logic signed [2*DATA_WIDTH-1:0] prod;
    s1_t                            s1;
    s2_t                            s2;

    mult_share_arbiter_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is combinational, so it is masked while reset is held low.
    assign bus.req_ready = reset ? grant : '0;
    assign accept        = |grant;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ptr <= '0;
        else if (accept)
            ptr <= (grant_idx == TW'(NUM_REQ - 1)) ? '0 : grant_idx + TW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
        end else begin
            s1.v <= accept;
            if (accept) begin
                s1.a   <= bus.req_a[grant_idx];
                s1.b   <= bus.req_b[grant_idx];
                s1.tag <= grant_idx;
            end
        end
    end

    assign prod = $signed(s1.a) * $signed(s1.b);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2 <= '0;
        end else begin
            s2.v   <= s1.v;
            s2.tag <= s1.tag;
            s2.res <= s1.v ? DATA_WIDTH'(dequantize(wide_t'(prod), QUANT_BITS, DATA_WIDTH)) : '0;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (s2.v)
            bus.rsp_valid[s2.tag] = 1'b1;
    end

    assign bus.rsp_data = s2.res;
    assign bus.busy     = s1.v | s2.v;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed scoreboard bench for mult_share_arbiter (4 clients, 32-bit, 10 fraction bits).
module tb_mult_share_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    mult_share_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

    mult_share_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .QUANT_BITS(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

`ifdef MULT_SHARE_SAT_EN
    localparam logic [31:0] MAX_SQ = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] MAX_SQ = 32'hFFC0_0000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i] = a;
        bus.req_b[i] = b;
    endtask

    // Drive valids, check the grant mid-cycle, queue the expected response, advance one cycle.
    task automatic step(input logic [3:0] v, input logic [3:0] exp_rdy, input logic push,
                        input logic [31:0] exp_d);
        bus.req_valid = v;
        @(negedge clock);
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (push && exp_rdy != 4'b0000)
            sb_q.push_back('{vld: exp_rdy, data: exp_d, cyc: cyc + 2});
        @(posedge clock);
        #1;
    endtask

    // Response monitor: every presented result must match the oldest queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (bus.rsp_valid != 4'b0000) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b data=0x%08h, expected no response",
                             bus.rsp_valid, bus.rsp_data);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_valid", 32'(bus.rsp_valid), 32'(e.vld));
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check("idle_rsp_data", bus.rsp_data, 32'h0);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] b_exp [4];
        b_exp = '{32'h0000_0800, 32'h0000_1800, 32'h0000_3000, 32'h0000_5000};

        bus.req_valid = 4'b0000;
        bus.req_a     = '0;
        bus.req_b     = '0;

        // Reset state, with requests pending.
        repeat (2) @(posedge clock);
        #1;
        bus.req_valid = 4'b1111;
        #1;
        check("reset_req_ready", 32'(bus.req_ready), 32'h0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset_rsp_data", bus.rsp_data, 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // All four clients continuously valid from ptr=0.
        for (int i = 0; i < 4; i++)
            set_op(i, 32'(32'h400 * (i + 1)), 32'(32'h400 * (i + 2)));
        for (int k = 0; k < 8; k++)
            step(4'b1111, 4'(1 << (k % 4)), 1'b1, b_exp[k % 4]);
        check("busy_streaming", 32'(bus.busy), 32'h1);

        // Pointer movement with sparse requesters, signed and overflow operands.
        set_op(0, 32'hFFFF_F800, 32'hFFFF_FE00);
        set_op(1, 32'h0000_0C00, 32'h0000_1400);
        set_op(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        set_op(3, 32'hFFFF_FC00, 32'h0000_0400);
        step(4'b0010, 4'b0010, 1'b1, 32'h0000_3C00);
        step(4'b1010, 4'b1000, 1'b1, 32'hFFFF_FC00);
        step(4'b0010, 4'b0010, 1'b1, 32'h0000_3C00);
        step(4'b0111, 4'b0100, 1'b1, MAX_SQ);
        step(4'b0011, 4'b0001, 1'b1, 32'h0000_0400);
        step(4'b0010, 4'b0010, 1'b1, 32'h0000_3C00);

        // Sole requester gets every cycle.
        set_op(2, 32'h0000_0400, 32'h0000_0800);
        for (int k = 0; k < 3; k++)
            step(4'b0100, 4'b0100, 1'b1, 32'h0000_0800);

        // -1 * 1 in raw LSBs floors to -1 after the arithmetic shift.
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
        step(4'b0001, 4'b0001, 1'b1, 32'hFFFF_FFFF);
        step(4'b0000, 4'b0000, 1'b0, 32'h0);
        step(4'b0000, 4'b0000, 1'b0, 32'h0);
        check("busy_drained", 32'(bus.busy), 32'h0);

        // Reset with both pipeline stages full: nothing in flight may come back.
        for (int i = 0; i < 4; i++)
            set_op(i, 32'h0000_0400, 32'h0000_0800);
        step(4'b1111, 4'b0010, 1'b0, 32'h0);
        step(4'b1111, 4'b0100, 1'b0, 32'h0);
        check("busy_before_reset", 32'(bus.busy), 32'h1);
        reset = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("midreset_busy", 32'(bus.busy), 32'h0);
        check("midreset_rsp_data", bus.rsp_data, 32'h0);
        check("midreset_req_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(4'b1111, 4'b0001, 1'b1, 32'h0000_0800);
        step(4'b0000, 4'b0000, 1'b0, 32'h0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++)
            @(posedge clock);
        @(negedge clock);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses still outstanding, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
